// File: rtl/alsu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alsu_cmd_sequencer
//   Upstream command stage for the ALSU. Packed commands are buffered in a small
//   FIFO and issued one per cycle onto the registered ALSU input pins. Each
//   command is issued repeat+1 times back to back, which lets a single command
//   drive a multi-step shift/rotate sequence. A LATENCY-deep delay line flags
//   the cycle in which the ALSU result for each issue is valid.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   cmd_valid    in   command present on cmd_data
//   cmd_ready    out  FIFO can accept a command (not full)
//   cmd_data     in   {repeat,bypass_B,bypass_A,red_op_B,red_op_A,direction,
//                      serial_in,cin,opcode[2:0],B[2:0],A[2:0]}
//   stall        in   suppress issue at the next edge
//   A,B,opcode,cin,serial_in,direction,red_op_A,red_op_B,bypass_A,bypass_B
//                out  registered ALSU input pins
//   issue_valid  out  pins carry a real command this cycle
//   res_valid    out  issue_valid delayed LATENCY cycles
//   fifo_count   out  number of stored commands
//   busy         out  sequencer not idle or FIFO not empty
// -----------------------------------------------------------------------------
module alsu_cmd_sequencer #(
    parameter int         DEPTH       = 4,
    parameter int         RPT_W       = 4,
    parameter int         LATENCY     = 2,
    parameter logic [2:0] IDLE_OPCODE = 3'b111
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [16+RPT_W-1:0]          cmd_data,
    input  logic                         stall,
    output logic [2:0]                   A,
    output logic [2:0]                   B,
    output logic [2:0]                   opcode,
    output logic                         cin,
    output logic                         serial_in,
    output logic                         direction,
    output logic                         red_op_A,
    output logic                         red_op_B,
    output logic                         bypass_A,
    output logic                         bypass_B,
    output logic                         issue_valid,
    output logic                         res_valid,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         busy
);

    localparam int CMD_W = 16 + RPT_W;
    localparam int FLD_W = 16;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [RPT_W-1:0] RPT_ZERO  = {RPT_W{1'b0}};
    localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);
    // Idle word: only the reserved opcode is non-zero so the ALSU holds its output.
    localparam logic [FLD_W-1:0] IDLE_WORD = {7'b0000000, IDLE_OPCODE, 6'b000000};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_STALL = 2'b10
    } state_t;

    logic [CMD_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    state_t             state_q;
    state_t             state_d;
    logic [FLD_W-1:0]   cur_q;
    logic [FLD_W-1:0]   cur_d;
    logic [RPT_W-1:0]   rpt_q;
    logic [RPT_W-1:0]   rpt_d;
    logic [FLD_W-1:0]   word_q;
    logic [FLD_W-1:0]   word_d;
    logic               iv_q;
    logic               iv_d;
    logic [LATENCY-1:0] rv_pipe_q;

    logic               ready_s;
    logic               push_s;
    logic               pop_s;
    logic               empty_s;
    logic [CMD_W-1:0]   head_s;

    assign ready_s = (count_q != FULL_CNT);
    assign empty_s = (count_q == CNT_ZERO);
    assign push_s  = cmd_valid & ready_s;
    assign head_s  = mem_q[rd_ptr_q];

    // FIFO storage: write the incoming command at the write pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {CMD_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= cmd_data;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Issue FSM next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rpt_d   = rpt_q;
        word_d  = IDLE_WORD;
        iv_d    = 1'b0;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s && !stall) begin
                    pop_s   = 1'b1;
                    cur_d   = head_s[FLD_W-1:0];
                    rpt_d   = head_s[CMD_W-1:FLD_W];
                    word_d  = head_s[FLD_W-1:0];
                    iv_d    = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (stall) begin
                    // Only park in STALL when repeats are still owed; the held
                    // command and its counter stay untouched.
                    if (rpt_q != RPT_ZERO) begin
                        state_d = ST_STALL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (rpt_q != RPT_ZERO) begin
                    word_d = cur_q;
                    rpt_d  = rpt_q - RPT_ONE;
                    iv_d   = 1'b1;
                end else if (!empty_s) begin
                    // Back-to-back pop: no bubble between consecutive commands.
                    pop_s  = 1'b1;
                    cur_d  = head_s[FLD_W-1:0];
                    rpt_d  = head_s[CMD_W-1:FLD_W];
                    word_d = head_s[FLD_W-1:0];
                    iv_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (stall) begin
                    state_d = ST_STALL;
                end else begin
                    word_d  = cur_q;
                    rpt_d   = rpt_q - RPT_ONE;
                    iv_d    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rpt_d   = RPT_ZERO;
            end
        endcase
    end

    // FSM state, held command and registered ALSU-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cur_q   <= {FLD_W{1'b0}};
            rpt_q   <= RPT_ZERO;
            word_q  <= IDLE_WORD;
            iv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rpt_q   <= rpt_d;
            word_q  <= word_d;
            iv_q    <= iv_d;
        end
    end

    // Result-valid delay line: res_valid follows issue_valid by LATENCY cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rv_pipe_q <= {LATENCY{1'b0}};
        end else begin
            rv_pipe_q[0] <= iv_q;
            for (int i = 1; i < LATENCY; i++) begin
                rv_pipe_q[i] <= rv_pipe_q[i-1];
            end
        end
    end

    assign A           = word_q[2:0];
    assign B           = word_q[5:3];
    assign opcode      = word_q[8:6];
    assign cin         = word_q[9];
    assign serial_in   = word_q[10];
    assign direction   = word_q[11];
    assign red_op_A    = word_q[12];
    assign red_op_B    = word_q[13];
    assign bypass_A    = word_q[14];
    assign bypass_B    = word_q[15];
    assign issue_valid = iv_q;
    assign res_valid   = rv_pipe_q[LATENCY-1];
    assign cmd_ready   = ready_s;
    assign fifo_count  = count_q;
    assign busy        = (state_q != ST_IDLE) || !empty_s;

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alsu_cmd_sequencer
//   Self-checking bench for alsu_cmd_sequencer. Directed scenarios plus random
//   traffic, all compared every cycle against a transaction-level model: a
//   queue of pending commands, the command being repeated and the number of
//   issues it still owes.
// -----------------------------------------------------------------------------
module tb_alsu_cmd_sequencer;

    localparam int         DEPTH     = 4;
    localparam int         RPT_W     = 4;
    localparam int         LATENCY   = 2;
    localparam logic [2:0] IDLE_OP   = 3'b111;
    localparam logic [15:0] IDLE_WORD = {7'b0000000, IDLE_OP, 6'b000000};

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [19:0] cmd_data;
    logic        stall;
    logic [2:0]  A;
    logic [2:0]  B;
    logic [2:0]  opcode;
    logic        cin;
    logic        serial_in;
    logic        direction;
    logic        red_op_A;
    logic        red_op_B;
    logic        bypass_A;
    logic        bypass_B;
    logic        issue_valid;
    logic        res_valid;
    logic [2:0]  fifo_count;
    logic        busy;

    alsu_cmd_sequencer #(
        .DEPTH      (DEPTH),
        .RPT_W      (RPT_W),
        .LATENCY    (LATENCY),
        .IDLE_OPCODE(IDLE_OP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .stall      (stall),
        .A          (A),
        .B          (B),
        .opcode     (opcode),
        .cin        (cin),
        .serial_in  (serial_in),
        .direction  (direction),
        .red_op_A   (red_op_A),
        .red_op_B   (red_op_B),
        .bypass_A   (bypass_A),
        .bypass_B   (bypass_B),
        .issue_valid(issue_valid),
        .res_valid  (res_valid),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [19:0] mq[$];
    logic [15:0] m_cur;
    int          m_rem;
    logic        m_iv;
    logic [15:0] m_word;
    logic        iv_hist[$];
    logic        m_busy;
    logic        acc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        iv_hist.delete();
        m_cur  = 16'h0000;
        m_rem  = 0;
        m_iv   = 1'b0;
        m_word = IDLE_WORD;
        m_busy = 1'b0;
    endtask

    function automatic logic exp_res();
        return (iv_hist.size() > LATENCY) ? iv_hist[LATENCY] : 1'b0;
    endfunction

    task automatic check_all();
        logic [15:0] dut_word;
        dut_word = {bypass_B, bypass_A, red_op_B, red_op_A, direction,
                    serial_in, cin, opcode, B, A};
        check_val("issue_valid", 32'(issue_valid), 32'(m_iv));
        check_val("alsu_word",   32'(dut_word),    32'(m_word));
        check_val("res_valid",   32'(res_valid),   32'(exp_res()));
        check_val("fifo_count",  32'(fifo_count),  32'(mq.size()));
        check_val("cmd_ready",   32'(cmd_ready),   32'(mq.size() != DEPTH));
        check_val("busy",        32'(busy),        32'(m_busy));
    endtask

    // One clock: drive inputs, predict the post-edge state, then compare.
    task automatic step(input logic v, input logic [19:0] d, input logic s, output logic accepted);
        int          cnt;
        logic        issued;
        logic [19:0] h;
        cmd_valid = v;
        cmd_data  = d;
        stall     = s;
        cnt       = mq.size();
        issued    = 1'b0;
        if (!s) begin
            if (m_rem > 0) begin
                m_rem--;
                issued = 1'b1;
            end else if (mq.size() != 0) begin
                h      = mq.pop_front();
                m_cur  = h[15:0];
                m_rem  = int'(h[19:16]);
                issued = 1'b1;
            end
        end
        m_iv     = issued;
        m_word   = issued ? m_cur : IDLE_WORD;
        accepted = v && (cnt < DEPTH);
        if (accepted) mq.push_back(d);
        iv_hist.push_front(issued);
        if (iv_hist.size() > LATENCY + 1) void'(iv_hist.pop_back());
        m_busy = issued || (m_rem > 0) || (mq.size() != 0);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset: outputs must go idle without waiting for a clock edge.
    task automatic do_reset();
        cmd_valid = 1'b0;
        stall     = 1'b0;
        rst       = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && m_busy; i++) begin
            step(1'b0, 20'h00000, 1'b0, acc);
        end
        check_val("drain_busy", 32'(busy), 32'(0));
    endtask

    function automatic logic [19:0] rand_cmd(input int max_rpt);
        logic [3:0] r;
        r = 4'($urandom_range(max_rpt, 0));
        return {r, 16'($urandom)};
    endfunction

    initial begin
        logic [19:0] c5;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 20'h00000;
        stall     = 1'b0;
        model_reset();
        #2;
        do_reset();

        // T1: single command, no repeat.
        step(1'b1, {4'd0, 7'b0000000, 3'b000, 3'b011, 3'b101}, 1'b0, acc);
        repeat (5) step(1'b0, 20'h00000, 1'b0, acc);

        // T2: shift command repeated 3 extra times.
        step(1'b1, {4'd3, 4'b0000, 1'b1, 1'b1, 1'b0, 3'b100, 3'b000, 3'b000}, 1'b0, acc);
        repeat (7) step(1'b0, 20'h00000, 1'b0, acc);

        // T3: fill while stalled, hold a 5th command until there is room.
        drain();
        for (int i = 0; i < 4; i++) step(1'b1, {4'd0, 12'h000, 4'(i)}, 1'b1, acc);
        c5 = {4'd0, 12'h0A0, 4'h5};
        step(1'b1, c5, 1'b1, acc);
        step(1'b1, c5, 1'b1, acc);
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, c5, 1'b0, acc);
        check_val("t3_fifth_accepted", 32'(acc), 32'(1));
        repeat (8) step(1'b0, 20'h00000, 1'b0, acc);

        // T4: repeat 5 with a two-edge stall after the 2nd issue.
        drain();
        step(1'b1, {4'd5, 16'h2C4B}, 1'b0, acc);
        step(1'b0, 20'h00000, 1'b0, acc);
        step(1'b0, 20'h00000, 1'b0, acc);
        step(1'b0, 20'h00000, 1'b1, acc);
        step(1'b0, 20'h00000, 1'b1, acc);
        repeat (8) step(1'b0, 20'h00000, 1'b0, acc);

        // T5: reset in the middle of a repeat with more commands queued.
        drain();
        step(1'b1, {4'd7, 16'h0E5A}, 1'b0, acc);
        step(1'b1, {4'd2, 16'h3333}, 1'b0, acc);
        repeat (2) step(1'b0, 20'h00000, 1'b0, acc);
        do_reset();
        repeat (5) step(1'b0, 20'h00000, 1'b0, acc);

        // T6: push and pop on the same edge at fifo_count=2.
        step(1'b1, {4'd0, 16'h1111}, 1'b1, acc);
        step(1'b1, {4'd1, 16'h2222}, 1'b1, acc);
        step(1'b1, {4'd0, 16'h4444}, 1'b0, acc);
        repeat (10) step(1'b0, 20'h00000, 1'b0, acc);

        // Random traffic, light stall, mostly short repeats.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(99, 0) < 55,
                 rand_cmd(($urandom_range(9, 0) == 0) ? 15 : 2),
                 $urandom_range(99, 0) < 15, acc);
        end

        // Random traffic, heavy stall and pressure, one reset in the middle.
        for (int i = 0; i < 500; i++) begin
            if (i == 200) do_reset();
            step($urandom_range(99, 0) < 80,
                 rand_cmd(($urandom_range(3, 0) == 0) ? 15 : 4),
                 $urandom_range(99, 0) < 40, acc);
        end

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
